// File: rtl/scm_access_ctrl_pkg.sv
// Shared types for the single-row SCM access controller.
// Optional perf counters are enabled with SCM_ACCESS_CTRL_PERF_CNT_EN.
package scm_access_ctrl_pkg;

    localparam int unsigned PERF_CNT_WIDTH = 32;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        SETTLE = 2'd2
    } scm_ctrl_state_e;

endpackage

// File: rtl/scm_rr_arbiter.sv
// N-way round-robin arbiter: search starts at the pointer, pointer moves to
// one past the winner when i_adv_en is set and a request is present.
module scm_rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    input  logic         i_adv_en,
    output logic [N-1:0] o_gnt
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_next;
    logic          w_found;
    logic [31:0]   w_idx;
    logic [31:0]   w_nxt;

    always_comb begin
        o_gnt      = '0;
        w_ptr_next = r_ptr;
        w_found    = 1'b0;
        w_idx      = '0;
        w_nxt      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_idx = (32'(r_ptr) + i) % N;
            if (!w_found && i_req[w_idx[PW-1:0]]) begin
                w_found                = 1'b1;
                o_gnt[w_idx[PW-1:0]]   = 1'b1;
                w_nxt                  = (w_idx + 32'd1) % N;
                w_ptr_next             = w_nxt[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_adv_en && w_found) begin
            r_ptr <= w_ptr_next;
        end
    end

endmodule

// File: rtl/scm_1row_access_ctrl.sv
// Access controller for a single-row latch SCM: round-robin writes, reads blocked
// during write commits, row init after reset. Perf counters: SCM_ACCESS_CTRL_PERF_CNT_EN.
module scm_1row_access_ctrl
    import scm_access_ctrl_pkg::*;
#(
    parameter int unsigned             WDATA_WIDTH = 64,
    parameter int unsigned             RDATA_WIDTH = 32,
    parameter int unsigned             RADDR_WIDTH = $clog2(WDATA_WIDTH / RDATA_WIDTH),
    parameter int unsigned             N_READ      = 4,
    parameter int unsigned             N_WREQ      = 3,
    parameter logic [WDATA_WIDTH-1:0]  INIT_VALUE  = '0
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [N_WREQ-1:0]                       wr_req_i,
    input  logic [N_WREQ-1:0][WDATA_WIDTH-1:0]      wr_data_i,
    output logic [N_WREQ-1:0]                       wr_gnt_o,
    input  logic [N_READ-1:0]                       rd_req_i,
    input  logic [N_READ-1:0][RADDR_WIDTH-1:0]      rd_addr_i,
    output logic [N_READ-1:0]                       rd_gnt_o,
    output logic [N_READ-1:0]                       rd_rvalid_o,
    output logic [N_READ-1:0][RDATA_WIDTH-1:0]      rd_rdata_o,
    output logic                                    scm_write_enable_o,
    output logic [WDATA_WIDTH-1:0]                  scm_write_data_o,
    output logic [N_READ-1:0]                       scm_read_enable_o,
    output logic [N_READ-1:0][RADDR_WIDTH-1:0]      scm_read_addr_o,
    input  logic [N_READ-1:0][RDATA_WIDTH-1:0]      scm_read_data_i,
`ifdef SCM_ACCESS_CTRL_PERF_CNT_EN
    input  logic                                    perf_clr_i,
    output logic [PERF_CNT_WIDTH-1:0]               perf_wr_cnt_o,
    output logic [PERF_CNT_WIDTH-1:0]               perf_rd_stall_cnt_o,
`endif
    output logic                                    init_done_o
);

    scm_ctrl_state_e            r_state;
    scm_ctrl_state_e            w_state_next;
    logic                       w_wr_grant;
    logic                       w_rd_serve;
    logic [N_WREQ-1:0]          w_arb_gnt;
    logic [WDATA_WIDTH-1:0]     w_win_data;
    logic [N_READ-1:0]          r_rvalid;
    logic                       r_init_done;

    scm_rr_arbiter #(
        .N (N_WREQ)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    (wr_req_i),
        .i_adv_en (w_wr_grant),
        .o_gnt    (w_arb_gnt)
    );

    always_comb begin
        w_win_data = '0;
        for (int unsigned i = 0; i < N_WREQ; i++) begin
            if (w_arb_gnt[i]) w_win_data = w_win_data | wr_data_i[i];
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_wr_grant         = 1'b0;
        w_rd_serve         = 1'b0;
        scm_write_enable_o = 1'b0;
        scm_write_data_o   = '0;
        case (r_state)
            INIT: begin
                scm_write_enable_o = 1'b1;
                scm_write_data_o   = INIT_VALUE;
                w_state_next       = SETTLE;
            end
            IDLE: begin
                if (|wr_req_i) begin
                    w_wr_grant         = 1'b1;
                    scm_write_enable_o = 1'b1;
                    scm_write_data_o   = w_win_data;
                    w_state_next       = SETTLE;
                end else begin
                    w_rd_serve = 1'b1;
                end
            end
            SETTLE: begin
                // Read-only slot: latches are stable after the previous commit.
                w_rd_serve   = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = INIT;
        endcase
    end

    assign wr_gnt_o          = w_wr_grant ? w_arb_gnt : '0;
    assign rd_gnt_o          = w_rd_serve ? rd_req_i : '0;
    assign scm_read_enable_o = w_rd_serve ? rd_req_i : '0;
    assign scm_read_addr_o   = w_rd_serve ? rd_addr_i : '0;
    assign rd_rvalid_o       = r_rvalid;
    assign init_done_o       = r_init_done;

    always_comb begin
        for (int unsigned p = 0; p < N_READ; p++) begin
            rd_rdata_o[p] = r_rvalid[p] ? scm_read_data_i[p] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= INIT;
            r_rvalid    <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_rvalid <= rd_gnt_o;
            if (r_state == SETTLE) r_init_done <= 1'b1;
        end
    end

`ifdef SCM_ACCESS_CTRL_PERF_CNT_EN
    logic [PERF_CNT_WIDTH-1:0] r_perf_wr;
    logic [PERF_CNT_WIDTH-1:0] r_perf_stall;
    logic                      w_rd_stall;

    assign w_rd_stall          = |(rd_req_i & ~rd_gnt_o);
    assign perf_wr_cnt_o       = r_perf_wr;
    assign perf_rd_stall_cnt_o = r_perf_stall;

    // Clear dominates; both counters saturate at all-ones.
    always_ff @(posedge clk) begin
        if (rst || perf_clr_i) begin
            r_perf_wr    <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_wr_grant && (r_perf_wr != '1)) r_perf_wr <= r_perf_wr + 1'b1;
            if (w_rd_stall && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 1'b1;
        end
    end
`else
    // Perf counters not built.
`endif

endmodule

// File: tb/tb_scm_1row_access_ctrl.sv
// Directed bench for scm_1row_access_ctrl with a behavioural single-row SCM.
// Perf checks are included when SCM_ACCESS_CTRL_PERF_CNT_EN is defined.
module tb_scm_1row_access_ctrl;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [2:0]            wr_req;
    logic [2:0][63:0]      wr_data;
    logic [2:0]            wr_gnt;
    logic [3:0]            rd_req;
    logic [3:0][0:0]       rd_addr;
    logic [3:0]            rd_gnt;
    logic [3:0]            rd_rvalid;
    logic [3:0][31:0]      rd_rdata;
    logic                  scm_we;
    logic [63:0]           scm_wdata;
    logic [3:0]            scm_re;
    logic [3:0][0:0]       scm_raddr;
    logic [3:0][31:0]      scm_rdata;
    logic                  init_done;
`ifdef SCM_ACCESS_CTRL_PERF_CNT_EN
    logic                  perf_clr;
    logic [31:0]           perf_wr_cnt;
    logic [31:0]           perf_stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scm_1row_access_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .wr_req_i           (wr_req),
        .wr_data_i          (wr_data),
        .wr_gnt_o           (wr_gnt),
        .rd_req_i           (rd_req),
        .rd_addr_i          (rd_addr),
        .rd_gnt_o           (rd_gnt),
        .rd_rvalid_o        (rd_rvalid),
        .rd_rdata_o         (rd_rdata),
        .scm_write_enable_o (scm_we),
        .scm_write_data_o   (scm_wdata),
        .scm_read_enable_o  (scm_re),
        .scm_read_addr_o    (scm_raddr),
        .scm_read_data_i    (scm_rdata),
`ifdef SCM_ACCESS_CTRL_PERF_CNT_EN
        .perf_clr_i          (perf_clr),
        .perf_wr_cnt_o       (perf_wr_cnt),
        .perf_rd_stall_cnt_o (perf_stall_cnt),
`endif
        .init_done_o        (init_done)
    );

    // Behavioural SCM: row written on the edge, read word registered on the edge.
    logic [63:0] m_row;
    always @(posedge clk) begin
        if (scm_we) m_row <= scm_wdata;
        for (int p = 0; p < 4; p++) begin
            if (scm_re[p]) scm_rdata[p] <= scm_raddr[p][0] ? m_row[63:32] : m_row[31:0];
        end
    end

    typedef struct {
        logic [2:0] wr;
        logic [3:0] rd;
        logic [2:0] egnt;
        logic [3:0] ergnt;
        logic       ewe;
        logic [3:0] erv;
    } vec_t;

    vec_t tbl[17];
    logic [2:0][63:0] wd;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] exp_wd;

        wd[0] = 64'h1111_1111_0000_0001;
        wd[1] = 64'h2222_2222_0000_0002;
        wd[2] = 64'h3333_3333_0000_0003;

        //           wr      rd       egnt    ergnt    we    erv
        tbl[0]  = '{3'b111, 4'b0000, 3'b001, 4'b0000, 1'b1, 4'b0000};
        tbl[1]  = '{3'b111, 4'b1111, 3'b000, 4'b1111, 1'b0, 4'b0000};
        tbl[2]  = '{3'b111, 4'b1111, 3'b010, 4'b0000, 1'b1, 4'b1111};
        tbl[3]  = '{3'b111, 4'b1111, 3'b000, 4'b1111, 1'b0, 4'b0000};
        tbl[4]  = '{3'b111, 4'b1111, 3'b100, 4'b0000, 1'b1, 4'b1111};
        tbl[5]  = '{3'b111, 4'b1111, 3'b000, 4'b1111, 1'b0, 4'b0000};
        tbl[6]  = '{3'b111, 4'b0000, 3'b001, 4'b0000, 1'b1, 4'b1111};
        tbl[7]  = '{3'b000, 4'b0101, 3'b000, 4'b0101, 1'b0, 4'b0000};
        tbl[8]  = '{3'b000, 4'b0011, 3'b000, 4'b0011, 1'b0, 4'b0101};
        tbl[9]  = '{3'b101, 4'b0000, 3'b100, 4'b0000, 1'b1, 4'b0011};
        tbl[10] = '{3'b101, 4'b0000, 3'b000, 4'b0000, 1'b0, 4'b0000};
        tbl[11] = '{3'b101, 4'b0000, 3'b001, 4'b0000, 1'b1, 4'b0000};
        tbl[12] = '{3'b000, 4'b0000, 3'b000, 4'b0000, 1'b0, 4'b0000};
        tbl[13] = '{3'b001, 4'b0000, 3'b001, 4'b0000, 1'b1, 4'b0000};
        tbl[14] = '{3'b000, 4'b0000, 3'b000, 4'b0000, 1'b0, 4'b0000};
        tbl[15] = '{3'b000, 4'b1000, 3'b000, 4'b1000, 1'b0, 4'b0000};
        tbl[16] = '{3'b000, 4'b0000, 3'b000, 4'b0000, 1'b0, 4'b1000};

        rst = 1'b1;
        wr_req = '0;
        wr_data = wd;
        rd_req = '0;
        rd_addr = '0;
`ifdef SCM_ACCESS_CTRL_PERF_CNT_EN
        perf_clr = 1'b0;
`endif

        // Reset state
        tick();
        #1;
        chk("rst_wr_gnt", 64'(wr_gnt), 0);
        chk("rst_rd_gnt", 64'(rd_gnt), 0);
        chk("rst_rvalid", 64'(rd_rvalid), 0);
        chk("rst_scm_re", 64'(scm_re), 0);
        chk("rst_scm_raddr", 64'(scm_raddr), 0);
        chk("rst_init_done", 64'(init_done), 0);
        tick();
        rst = 1'b0;
        #1;
        // cycle 0: INIT
        chk("c0_we", 64'(scm_we), 1);
        chk("c0_wdata", scm_wdata, 64'h0);
        chk("c0_init_done", 64'(init_done), 0);
        tick(); #1;
        chk("c1_we", 64'(scm_we), 0);
        chk("c1_init_done", 64'(init_done), 0);
        tick(); #1;
        chk("c2_init_done", 64'(init_done), 1);
        tick();
        rd_req = 4'b0001;
        rd_addr[0] = 1'b1;
        #1;
        chk("c3_rd_gnt", 64'(rd_gnt), 64'h1);
        chk("c3_scm_re", 64'(scm_re), 64'h1);
        chk("c3_scm_raddr0", 64'(scm_raddr[0]), 1);
        tick();
        rd_req = '0;
        #1;
        chk("c4_rvalid", 64'(rd_rvalid), 64'h1);
        chk("c4_rdata0", 64'(rd_rdata[0]), 0);

        // Table-driven round-robin / read-blocking sequence
        for (int p = 0; p < 4; p++) rd_addr[p] = 1'(p % 2);
        for (int k = 0; k < 17; k++) begin
            tick();
            wr_req = tbl[k].wr;
            rd_req = tbl[k].rd;
            #1;
            chk($sformatf("v%0d_wr_gnt", k), 64'(wr_gnt), 64'(tbl[k].egnt));
            chk($sformatf("v%0d_rd_gnt", k), 64'(rd_gnt), 64'(tbl[k].ergnt));
            chk($sformatf("v%0d_scm_re", k), 64'(scm_re), 64'(tbl[k].ergnt));
            chk($sformatf("v%0d_we", k), 64'(scm_we), 64'(tbl[k].ewe));
            chk($sformatf("v%0d_rvalid", k), 64'(rd_rvalid), 64'(tbl[k].erv));
            if (tbl[k].ewe) begin
                exp_wd = '0;
                for (int i = 0; i < 3; i++) if (tbl[k].egnt[i]) exp_wd = wd[i];
                chk($sformatf("v%0d_wdata", k), scm_wdata, exp_wd);
            end
        end

        // Write colliding with a port-1 read: read slips one cycle and sees the new row
        tick();
        wr_data[0] = 64'hDEAD_BEEF_CAFE_F00D;
        wr_req = 3'b001;
        rd_req = 4'b0010;
        rd_addr[1] = 1'b0;
        #1;
        chk("col_wr_gnt", 64'(wr_gnt), 64'h1);
        chk("col_rd_gnt_blocked", 64'(rd_gnt), 0);
        chk("col_wdata", scm_wdata, 64'hDEAD_BEEF_CAFE_F00D);
        tick();
        wr_req = '0;
        #1;
        chk("col_rd_gnt_settle", 64'(rd_gnt), 64'h2);
        tick();
        rd_addr[1] = 1'b1;
        #1;
        chk("col_rvalid", 64'(rd_rvalid), 64'h2);
        chk("col_rdata_lo", 64'(rd_rdata[1]), 64'hCAFE_F00D);
        chk("col_rd_gnt_hi", 64'(rd_gnt), 64'h2);
        tick();
        rd_req = '0;
        #1;
        chk("col_rdata_hi", 64'(rd_rdata[1]), 64'hDEAD_BEEF);
        tick(); #1;
        chk("col_rvalid_drop", 64'(rd_rvalid), 0);
        chk("col_rdata_qual", 64'(rd_rdata[1]), 0);

        // Reset in SETTLE with a read in flight; pointer must return to 0
        tick();
        wr_req = 3'b010;
        #1;
        chk("mr_wr_gnt", 64'(wr_gnt), 64'h2);
        tick();
        wr_req = '0;
        rd_req = 4'b0100;
        rst = 1'b1;
        #1;
        chk("mr_settle_rd_gnt", 64'(rd_gnt), 64'h4);
        tick();
        rst = 1'b0;
        rd_req = '0;
        #1;
        chk("mr_rvalid", 64'(rd_rvalid), 0);
        chk("mr_init_we", 64'(scm_we), 1);
        chk("mr_init_wdata", scm_wdata, 64'h0);
        chk("mr_init_done", 64'(init_done), 0);
        tick(); #1;
        tick();
        wr_req = 3'b110;
        #1;
        chk("mr_ptr_cleared", 64'(wr_gnt), 64'h2);
        chk("mr_init_done_hi", 64'(init_done), 1);
        tick();
        wr_req = '0;
        #1;

`ifdef SCM_ACCESS_CTRL_PERF_CNT_EN
        tick();
        perf_clr = 1'b1;
        #1;
        tick();
        perf_clr = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            tick();
            wr_req = 3'b001;
            rd_req = (k < 2) ? 4'b0001 : 4'b0000;
            #1;
            tick();
            wr_req = '0;
            rd_req = '0;
            #1;
        end
        tick(); #1;
        chk("perf_wr_cnt", 64'(perf_wr_cnt), 5);
        chk("perf_stall_cnt", 64'(perf_stall_cnt), 2);
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        #1;
        chk("perf_wr_clr", 64'(perf_wr_cnt), 0);
        chk("perf_stall_clr", 64'(perf_stall_cnt), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
